// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the raster scan generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{
        video_on: 1'b0,
        hsync:    1'b1,
        vsync:    1'b1
    };

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_DLY = 1;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan bundle from the raster generator to sprite/compositor logic.
interface vga_scan_gen_if;
    import vga_pkg::*;

    logic   pix_tick;
    coord_t pixelx;
    coord_t pixely;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_start;

    modport master (
        output pix_tick, pixelx, pixely,
        output video_on, hsync, vsync,
        output frame_start
    );

    modport slave (
        input pix_tick, pixelx, pixely,
        input video_on, hsync, vsync,
        input frame_start
    );

endinterface

// File: rtl/vga_scan_gen_scan_delay.sv
// Pixel-tick enabled shift register for sync/video_on; resets to idle.
module scan_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    sync_t [DEPTH:0] stg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= {(DEPTH+1){SYNC_IDLE}};
        end else if (en) begin
            stg[0] <= d;
            for (int i = 1; i <= DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH];

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel divider, x/y counters, sync decode
// and a pixel-tick delay line aligning sync with sprite ROM latency.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_DLY = DEF_PIPE_DLY
) (
    input logic clk,
    input logic rst,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam coord_t   H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t   V_LAST   = coord_t'(V_TOTAL - 1);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed 10-bit range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
        $error("vga_scan_gen: CLK_DIV must be 1..4");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_bad_dly
        $error("vga_scan_gen: PIPE_DLY must be 0..3");
    end

    logic [1:0] div_q;
    logic       tick_q;
    coord_t     x_q, y_q;
    coord_t     x_n, y_n;
    logic       last_x, last_y;
    logic       wrap;
    logic       fs_q;
    sync_t      raw;
    sync_t      dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DIV_LAST);
            div_q  <= (div_q == DIV_LAST) ? 2'd0
                                          : div_q + 2'd1;
        end
    end

    always_comb begin
        x_n    = x_q;
        y_n    = y_q;
        last_x = (x_q == H_LAST);
        last_y = (y_q == V_LAST);
        wrap   = tick_q && last_x && last_y;
        if (tick_q) begin
            if (last_x) begin
                x_n = '0;
                y_n = last_y ? '0 : y_q + 10'd1;
            end else begin
                x_n = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_n;
            y_q  <= y_n;
            fs_q <= wrap;
        end
    end

    // Decoded from the next counter values so a depth-0 line tracks x/y exactly.
    always_comb begin
        raw.video_on = (int'(x_n) < H_ACTIVE) &&
                       (int'(y_n) < V_ACTIVE);
        raw.hsync    = !((int'(x_n) >= HS_BEG) &&
                         (int'(x_n) < HS_END));
        raw.vsync    = !((int'(y_n) >= VS_BEG) &&
                         (int'(y_n) < VS_END));
    end

    scan_delay #(
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (tick_q),
        .d   (raw),
        .q   (dly)
    );

    assign vga.pix_tick    = tick_q;
    assign vga.pixelx      = x_q;
    assign vga.pixely      = y_q;
    assign vga.video_on    = dly.video_on;
    assign vga.hsync       = dly.hsync;
    assign vga.vsync       = dly.vsync;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: closed-form timing model, checkpoint table,
// frame totals on reduced timings and randomized resets.
module tb_vga_scan_gen;
    import vga_pkg::*;

    typedef struct {
        int cd, pd;
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
    } tim_t;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        longint t;
        int     x;
        int     y;
        bit     hs;
        bit     vid;
        bit     fs;
    } row_t;

    tim_t ta = '{2, 1, 640, 16, 96, 48, 480, 10, 2, 33};
    tim_t tb = '{1, 0, 20, 3, 5, 4, 10, 2, 2, 3};
    tim_t tc = '{3, 3, 20, 3, 5, 4, 10, 2, 2, 3};

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int     vectors = 0;
    int     errors  = 0;
    longint ka = 0, kb = 0;
    bit     arm_a = 0, arm_b = 0;

    vga_scan_gen_if ifa();
    vga_scan_gen_if ifb();
    vga_scan_gen_if ifc();

    vga_scan_gen u_a (.clk(clk), .rst(rst_a), .vga(ifa));

    vga_scan_gen #(
        .CLK_DIV(1), .PIPE_DLY(0),
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (.clk(clk), .rst(rst_b), .vga(ifb));

    vga_scan_gen #(
        .CLK_DIV(3), .PIPE_DLY(3),
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_c (.clk(clk), .rst(rst_b), .vga(ifc));

    // Edges since the last reset edge: the whole schedule follows from it.
    function automatic longint ticks(longint k, int cd);
        return (k == 0) ? 0 : (k - 1) / cd;
    endfunction

    function automatic obs_t model(tim_t m, longint k);
        obs_t   o;
        longint ht, vt, fr, t, p, q;
        int     qx, qy;
        ht = m.ha + m.hf + m.hsw + m.hb;
        vt = m.va + m.vf + m.vsw + m.vb;
        fr = ht * vt;
        t  = ticks(k, m.cd);
        p  = t % fr;
        o.tick = (k >= 1) && (k % m.cd == 0);
        o.x    = 10'(p % ht);
        o.y    = 10'(p / ht);
        o.fs   = (k >= 2) && ((k - 1) % m.cd == 0) &&
                 (t > 0) && (p == 0);
        if (t - m.pd >= 1) begin
            q     = (t - m.pd) % fr;
            qx    = int'(q % ht);
            qy    = int'(q / ht);
            o.vid = (qx < m.ha) && (qy < m.va);
            o.hs  = !(qx >= m.ha + m.hf &&
                      qx < m.ha + m.hf + m.hsw);
            o.vs  = !(qy >= m.va + m.vf &&
                      qy < m.va + m.vf + m.vsw);
        end else begin
            o.vid = 1'b0;
            o.hs  = 1'b1;
            o.vs  = 1'b1;
        end
        return o;
    endfunction

    task automatic check(string nm, obs_t g, obs_t e);
        vectors++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s t=%0t got tick=%b x=%0d y=%0d vid=%b hs=%b vs=%b fs=%b required tick=%b x=%0d y=%0d vid=%b hs=%b vs=%b fs=%b",
                     nm, $time, g.tick, g.x, g.y, g.vid, g.hs, g.vs, g.fs,
                     e.tick, e.x, e.y, e.vid, e.hs, e.vs, e.fs);
        end
    endtask

    task automatic check_int(string nm, longint g, longint e);
        vectors++;
        if (g != e) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, g, e);
        end
    endtask

    function automatic obs_t grab_a();
        return {ifa.pix_tick, ifa.pixelx, ifa.pixely, ifa.video_on,
                ifa.hsync, ifa.vsync, ifa.frame_start};
    endfunction

    always @(posedge clk) begin
        if (rst_a) begin ka = 0; arm_a = 1; end else ka++;
        if (rst_b) begin kb = 0; arm_b = 1; end else kb++;
    end

    always @(negedge clk) begin
        if (arm_a) check("model_a", grab_a(), model(ta, ka));
        if (arm_b) begin
            check("model_b",
                  {ifb.pix_tick, ifb.pixelx, ifb.pixely, ifb.video_on,
                   ifb.hsync, ifb.vsync, ifb.frame_start},
                  model(tb, kb));
            check("model_c",
                  {ifc.pix_tick, ifc.pixelx, ifc.pixely, ifc.video_on,
                   ifc.hsync, ifc.vsync, ifc.frame_start},
                  model(tc, kb));
        end
    end

    // Whole-frame totals between consecutive frame_start strobes.
    longint ft[2], fv[2], fl[2];
    bit     seen[2];
    always @(negedge clk) begin
        logic tk, vd, vs, fs;
        for (int i = 0; i < 2; i++) begin
            tk = (i == 0) ? ifb.pix_tick    : ifc.pix_tick;
            vd = (i == 0) ? ifb.video_on    : ifc.video_on;
            vs = (i == 0) ? ifb.vsync       : ifc.vsync;
            fs = (i == 0) ? ifb.frame_start : ifc.frame_start;
            if (kb == 0) seen[i] = 0;
            if (fs) begin
                if (seen[i]) begin
                    check_int("frame_ticks", ft[i], 32 * 17);
                    check_int("video_ticks", fv[i], 20 * 10);
                    check_int("vsync_low",   fl[i], 2 * 32);
                end
                seen[i] = 1;
                ft[i] = 0; fv[i] = 0; fl[i] = 0;
            end
            if (tk) begin
                ft[i]++;
                if (vd) fv[i]++;
                if (!vs) fl[i]++;
            end
        end
    end

    task automatic wait_tick_a(longint t);
        int n = 0;
        while (ticks(ka, 2) < t && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check_int("wait_tick_a", ticks(ka, 2), t);
    endtask

    row_t rows[$];

    initial begin
        obs_t g;
        rows = '{
            '{0,    0,   0,  1, 0, 0},
            '{1,    1,   0,  1, 0, 0},
            '{2,    2,   0,  1, 1, 0},
            '{640,  640, 0,  1, 1, 0},
            '{641,  641, 0,  1, 0, 0},
            '{656,  656, 0,  1, 0, 0},
            '{657,  657, 0,  0, 0, 0},
            '{752,  752, 0,  0, 0, 0},
            '{753,  753, 0,  1, 0, 0},
            '{800,  0,   1,  1, 0, 0},
            '{801,  1,   1,  1, 1, 0},
            '{8799, 799, 10, 1, 0, 0},
            '{8800, 0,   11, 1, 0, 0}
        };

        repeat (5) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        check_int("reset_tick", ifa.pix_tick, 0);
        check_int("reset_vsync", ifa.vsync, 1);
        @(negedge clk);
        check_int("tick_clk1", ifa.pix_tick, 0);
        @(negedge clk);
        check_int("tick_clk2", ifa.pix_tick, 1);
        check_int("x_before_tick", ifa.pixelx, 0);

        foreach (rows[i]) begin
            wait_tick_a(rows[i].t);
            g = grab_a();
            vectors++;
            if (g.x != 10'(rows[i].x) || g.y != 10'(rows[i].y) ||
                g.hs != rows[i].hs || g.vid != rows[i].vid ||
                g.fs != rows[i].fs) begin
                errors++;
                $display("FAIL row%0d got x=%0d y=%0d hs=%b vid=%b fs=%b required x=%0d y=%0d hs=%b vid=%b fs=%b",
                         i, g.x, g.y, g.hs, g.vid, g.fs,
                         rows[i].x, rows[i].y, rows[i].hs,
                         rows[i].vid, rows[i].fs);
            end
        end

        wait_tick_a(8800 + 300);
        check_int("pre_rst_x", ifa.pixelx, 300);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("mid_rst_a", grab_a(),
              '{tick: 1'b0, x: 10'd0, y: 10'd0, vid: 1'b0,
                hs: 1'b1, vs: 1'b1, fs: 1'b0});
        @(negedge clk);
        check_int("rst_tick1", ifa.pix_tick, 0);
        @(negedge clk);
        check_int("rst_tick2", ifa.pix_tick, 1);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(40, 1200)) @(negedge clk);
            rst_b = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_b = 1'b0;
        end
        repeat (4000) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
